// File: rtl/multi_ch_vec_reader.sv
// Multi-channel lockstep vector reader: streams num_elems addresses from shared
// memory channels through a small output FIFO with vector/element framing.
module multi_ch_vec_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_elems,
  input  logic                            abort,
  output logic                            rd_en,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(VEC_LEN)-1:0]      out_elem_idx,
  output logic                            out_vec_last,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int PW    = NUM_CH * DATA_WIDTH;
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] NUM_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_num, r_rd_cnt, r_pop_cnt;
  logic                  r_rd_pend, r_done;
  logic [PW-1:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [OCC_W-1:0]      r_occ;
  logic [IDX_W-1:0]      r_idx;

  logic                  w_launch, w_abort, w_push, w_pop, w_last_rd, w_room;
  logic [OCC_W:0]        w_outstanding;

  assign w_abort       = abort && (r_state != IDLE);
  assign w_launch      = (r_state == IDLE) && start && !abort;
  // A read in flight already owns a FIFO slot, so it counts against the space.
  assign w_outstanding = {1'b0, r_occ} + (OCC_W+1)'(r_rd_pend);
  assign w_room        = w_outstanding < (OCC_W+1)'(FIFO_DEPTH);

  assign rd_en     = (r_state == READ) && (r_rd_cnt != r_num) && w_room;
  assign rd_addr   = r_base + r_rd_cnt[ADDR_WIDTH-1:0];
  assign w_last_rd = rd_en && (r_rd_cnt == r_num - NUM_ONE);

  assign out_valid    = (r_occ != '0);
  assign w_push       = r_rd_pend;
  assign w_pop        = out_valid && out_ready;
  assign out_last     = out_valid && (r_pop_cnt == r_num - NUM_ONE);
  assign out_data     = out_valid ? r_mem[r_rptr] : '0;
  assign out_elem_idx = r_idx;
  assign out_vec_last = out_valid && ((r_idx == IDX_W'(VEC_LEN - 1)) || out_last);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_launch && (num_elems != '0)) w_next = READ;
      READ:    if (abort) w_next = IDLE;
               else if (w_last_rd) w_next = DRAIN;
      DRAIN:   if (abort) w_next = IDLE;
               else if (w_pop && out_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_num     <= '0;
      r_rd_cnt  <= '0;
      r_pop_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_done    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_idx     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_base    <= base_addr;
        r_num     <= num_elems;
        r_rd_cnt  <= '0;
        r_pop_cnt <= '0;
        r_idx     <= '0;
        r_done    <= (num_elems == '0);
      end
      // Abort flushes the FIFO and drops the pending read; done stays low.
      if (w_abort) begin
        r_rd_pend <= 1'b0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_occ     <= '0;
        r_idx     <= '0;
      end else begin
        r_rd_pend <= rd_en;
        if (rd_en) r_rd_cnt <= r_rd_cnt + NUM_ONE;
        if (w_push)
          r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
        if (w_pop) begin
          r_rptr    <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
          r_pop_cnt <= r_pop_cnt + NUM_ONE;
          r_idx     <= r_idx + IDX_W'(1);
        end
        if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
        else if (!w_push && w_pop) r_occ <= r_occ - OCC_W'(1);
        if (w_pop && out_last && (r_state == DRAIN)) r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_vec_reader.sv
// Randomized bench for multi_ch_vec_reader: memory model plus a per-element
// reference derived from base/length arithmetic.
module tb_multi_ch_vec_reader;
  localparam int DW = 8, NCH = 2, AW = 5, VL = 4, FD = 4;
  localparam int PW = NCH * DW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_elems = '0;
  logic          rd_en, out_valid, out_vec_last, out_last, busy, done;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, out_data;
  logic [1:0]    out_elem_idx;
  logic [PW-1:0] mem [32];
  int vectors = 0, errors = 0;

  multi_ch_vec_reader #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW),
                        .VEC_LEN(VL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_elems(num_elems), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_elem_idx(out_elem_idx), .out_vec_last(out_vec_last),
    .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Memory: one-cycle read latency; garbage when not enabled.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : PW'($urandom);

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [AW+PW+7:0] obs;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {rd_en, rd_addr, out_valid, out_data, out_elem_idx, out_vec_last,
           out_last, busy, done};
    vectors++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: ready=1; 1: random ready; 2: random ready with a 10-cycle stall.
  task automatic run_job(input logic [AW-1:0] b, input int n, input int mode,
                         input int abort_at, input int poke_at);
    int rk = 0, ak = 0, cyc, last_hs = -100, done_cnt = 0, done_cyc = -1;
    int first_rd = -1, first_v = -1;
    logic [PW+3:0] saved, cur, expv;
    logic pstall = 1'b0;
    logic [AW-1:0] ea;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_elems = (AW+1)'(n);
    out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 600; cyc++) begin
      if (mode != 0) out_ready = ($urandom_range(0, 2) != 0);
      if (mode == 2 && cyc >= 6 && cyc < 16) out_ready = 1'b0;
      if (cyc == poke_at) begin
        start = 1'b1; base_addr = b + AW'(7); num_elems = 6'd3;
      end else start = 1'b0;
      if (cyc == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({busy, out_valid, rd_en} !== 3'b000) begin
          errors++;
          $display("FAIL abort_idle got busy/valid/rd_en=%b exp 000", {busy, out_valid, rd_en});
        end
        for (int k = 0; k < 5; k++) begin
          vectors++;
          if ({done, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL abort_quiet got done/valid/busy=%b exp 000", {done, out_valid, busy});
          end
          @(negedge clk);
        end
        return;
      end
      cur = {out_data, out_elem_idx, out_vec_last, out_last};
      if (pstall) begin
        vectors++;
        if (out_valid !== 1'b1 || cur !== saved) begin
          errors++;
          $display("FAIL stall_stable got v=%b %h exp v=1 %h", out_valid, cur, saved);
        end
      end
      if (rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = cyc;
        ea = b + AW'(rk);
        rk++;
        vectors++;
        if (rd_addr !== ea || rk > n || rk - ak > FD) begin
          errors++;
          $display("FAIL rd_addr got %0d (#%0d, outstanding %0d) exp %0d (max %0d, <=%0d)",
                   rd_addr, rk, rk - ak, ea, n, FD);
        end
      end
      if (out_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (out_ready) begin
          expv = {mem[AW'(b + AW'(ak))], 2'(ak % VL),
                  (ak % VL == VL - 1) || (ak == n - 1), ak == n - 1};
          vectors++;
          if (cur !== expv) begin
            errors++;
            $display("FAIL element[%0d] got %h exp %h", ak, cur, expv);
          end
          if (ak == n - 1) last_hs = cyc;
          ak++;
        end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      pstall = out_valid && !out_ready;
      saved = cur;
      if (ak >= n && cyc >= last_hs + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (ak != n || rk != n) begin
      errors++;
      $display("FAIL job_count got rd=%0d out=%0d exp %0d", rk, ak, n);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL done_pulse got cnt=%0d at %0d exp 1 at %0d", done_cnt, done_cyc, last_hs + 1);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after got %b exp 0", busy);
    end
    if (mode == 0) begin
      vectors++;
      if (first_rd != 1 || first_v != 3 || last_hs != 3 + n - 1) begin
        errors++;
        $display("FAIL latency got rd@%0d v@%0d last@%0d exp 1 3 %0d",
                 first_rd, first_v, last_hs, 3 + n - 1);
      end
    end
  endtask

  task automatic test_basic();      run_job(5'd0, 8, 0, 0, 0);  endtask
  task automatic test_wrap();       run_job(5'd30, 4, 0, 0, 0); endtask
  task automatic test_back_to_back(); run_job(5'd17, 32, 0, 0, 0); endtask

  task automatic test_stall();
    run_job(AW'($urandom), 12, 2, 0, 0);
    run_job(AW'($urandom), 20, 1, 0, 0);
  endtask

  task automatic test_abort();
    run_job(5'd5, 10, 0, 3, 0);
    run_job(5'd5, 10, 0, 0, 0);
  endtask

  task automatic test_start_busy(); run_job(5'd9, 8, 0, 0, 4); endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; num_elems = '0; base_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({done, busy, rd_en} !== 3'b100) begin
      errors++;
      $display("FAIL zero_len got done/busy/rd_en=%b exp 100", {done, busy, rd_en});
    end
    @(negedge clk);
    vectors++;
    if ({done, busy, rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL zero_len_after got done/busy/rd_en=%b exp 000", {done, busy, rd_en});
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_elems = 6'd5; base_addr = 5'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({busy, rd_en, done} !== 3'b000) begin
        errors++;
        $display("FAIL start_abort got busy/rd_en/done=%b exp 000", {busy, rd_en, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    start = 1'b1; base_addr = 5'd12; num_elems = 6'd4; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if ({busy, out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL drain_setup got busy/valid=%b exp 11", {busy, out_valid});
    end
    test_reset();
    run_job(5'd28, 6, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++)
      run_job(AW'($urandom), $urandom_range(1, 32), 1, 0, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = PW'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_abort();
    test_zero_len();
    test_start_busy();
    test_start_abort_idle();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
